// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decode, BO/BI/CTR evaluation and target resolution
// in a 2-stage valid/ready pipeline with LR/CTR forwarding between branches.
module branch_resolve_unit #(
    parameter int         addressWidth   = 64,
    parameter int         immWidth       = 24,
    parameter logic [2:0] BranchUnitCode = 3'd3,
    parameter logic [4:0] formatI        = 5'd7,
    parameter logic [4:0] formatB        = 5'd2,
    parameter logic [4:0] formatXL       = 5'd18
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [2:0]              functionalUnitCode_i,
    input  logic [4:0]              instructionFormat_i,
    input  logic [5:0]              opCode_i,
    input  logic [9:0]              xOpCode_i,
    input  logic [4:0]              BO_i,
    input  logic [4:0]              BI_i,
    input  logic                    AA_i,
    input  logic                    LK_i,
    input  logic [immWidth-1:0]     imm_i,
    input  logic [addressWidth-1:0] instructionAddress_i,
    input  logic                    is64Bit_i,
    input  logic [31:0]             condReg_i,
    input  logic [addressWidth-1:0] countReg_i,
    input  logic [addressWidth-1:0] linkReg_i,
    input  logic [addressWidth-1:0] targetAddrReg_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    taken_o,
    output logic [addressWidth-1:0] target_o,
    output logic                    illegal_o,
    output logic                    linkWrite_o,
    output logic [addressWidth-1:0] linkVal_o,
    output logic                    ctrWrite_o,
    output logic [addressWidth-1:0] ctrVal_o
);

    localparam int AW = addressWidth;
    localparam logic [AW-1:0] LOW32 = {{(AW-32){1'b0}}, {32{1'b1}}};
    localparam logic [AW-1:0] ALIGN = {{(AW-2){1'b1}}, 2'b00};

    typedef struct packed {
        logic          uncond;
        logic          illegal;
        logic          dec;
        logic          lw;
        logic          is64;
        logic          bo0;
        logic          bo1;
        logic          bo2;
        logic          bo3;
        logic          crBit;
        logic [AW-1:0] ctrNew;
        logic [AW-1:0] target;
        logic [AW-1:0] linkVal;
        logic [AW-1:0] cia4;
    } br_s1_t;

    logic          isI, isB, isXL, isLr, isCtr, isTar;
    logic          s1_valid, s2_adv, capture;
    logic          ctrOk, condOk, taken_d;
    logic [AW-1:0] cia4, relBase, dispI, dispB;
    logic [AW-1:0] ctrSrc, lrSrc, target_d;
    br_s1_t        s1_d, s1_q;

    assign isI   = (instructionFormat_i == formatI) && (opCode_i == 6'd18);
    assign isB   = (instructionFormat_i == formatB) && (opCode_i == 6'd16);
    assign isXL  = (instructionFormat_i == formatXL) && (opCode_i == 6'd19);
    assign isLr  = isXL && (xOpCode_i == 10'd16);
    assign isCtr = isXL && (xOpCode_i == 10'd528) && BO_i[2];
    assign isTar = isXL && (xOpCode_i == 10'd560);

    assign cia4    = instructionAddress_i + AW'(4);
    assign relBase = AA_i ? '0 : instructionAddress_i;
    assign dispI   = {{(AW-immWidth-2){imm_i[immWidth-1]}}, imm_i, 2'b00};
    assign dispB   = {{(AW-16){imm_i[13]}}, imm_i[13:0], 2'b00};

    // Youngest in-flight writer wins; s2 drops out once it handshakes.
    always_comb begin
        ctrSrc = countReg_i;
        lrSrc  = linkReg_i;
        if (s1_valid && s1_q.dec)
            ctrSrc = s1_q.ctrNew;
        else if (valid_o && ctrWrite_o && !ready_i)
            ctrSrc = ctrVal_o;
        if (s1_valid && s1_q.lw)
            lrSrc = s1_q.linkVal;
        else if (valid_o && linkWrite_o && !ready_i)
            lrSrc = linkVal_o;
    end

    always_comb begin
        s1_d         = '0;
        s1_d.uncond  = isI;
        s1_d.illegal = !(isI || isB || isLr || isCtr || isTar);
        s1_d.dec     = (isB || isLr || isTar) && !BO_i[2];
        s1_d.lw      = LK_i && !s1_d.illegal;
        s1_d.is64    = is64Bit_i;
        s1_d.bo0     = BO_i[4];
        s1_d.bo1     = BO_i[3];
        s1_d.bo2     = BO_i[2];
        s1_d.bo3     = BO_i[1];
        s1_d.crBit   = condReg_i[5'd31 - BI_i];
        s1_d.ctrNew  = s1_d.dec ? ctrSrc - AW'(1) : ctrSrc;
        s1_d.cia4    = cia4;
        s1_d.linkVal = is64Bit_i ? cia4 : (cia4 & LOW32);
        unique case (1'b1)
            isI:     s1_d.target = relBase + dispI;
            isB:     s1_d.target = relBase + dispB;
            isLr:    s1_d.target = lrSrc & ALIGN;
            isCtr:   s1_d.target = ctrSrc & ALIGN;
            isTar:   s1_d.target = targetAddrReg_i & ALIGN;
            default: s1_d.target = cia4;
        endcase
    end

    always_comb begin
        ctrOk    = s1_q.bo2 |
                   ((s1_q.is64 ? |s1_q.ctrNew : |s1_q.ctrNew[31:0]) ^ s1_q.bo3);
        condOk   = s1_q.bo0 | (s1_q.crBit == s1_q.bo1);
        taken_d  = !s1_q.illegal && (s1_q.uncond || (ctrOk && condOk));
        target_d = taken_d ? s1_q.target : s1_q.cia4;
        if (!s1_q.is64)
            target_d = target_d & LOW32;
    end

    assign s2_adv  = !valid_o || ready_i;
    assign ready_o = !flush_i && (!s1_valid || s2_adv);
    assign capture = valid_i && ready_o &&
                     (functionalUnitCode_i == BranchUnitCode);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_valid    <= 1'b0;
            s1_q        <= '0;
            valid_o     <= 1'b0;
            taken_o     <= 1'b0;
            target_o    <= '0;
            illegal_o   <= 1'b0;
            linkWrite_o <= 1'b0;
            linkVal_o   <= '0;
            ctrWrite_o  <= 1'b0;
            ctrVal_o    <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            if (s2_adv) begin
                valid_o <= s1_valid;
                if (s1_valid) begin
                    taken_o     <= taken_d;
                    target_o    <= target_d;
                    illegal_o   <= s1_q.illegal;
                    linkWrite_o <= s1_q.lw;
                    linkVal_o   <= s1_q.linkVal;
                    ctrWrite_o  <= s1_q.dec;
                    ctrVal_o    <= s1_q.ctrNew;
                end
            end
            if (ready_o) begin
                s1_valid <= capture;
                if (capture)
                    s1_q <= s1_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomised bench for branch_resolve_unit, scored against
// a transaction-level model of in-flight branches.
module tb_branch_resolve_unit;

    logic        clock_i = 1'b0;
    logic        reset_i, flush_i, valid_i, ready_o, ready_i;
    logic [2:0]  functionalUnitCode_i;
    logic [4:0]  instructionFormat_i, BO_i, BI_i;
    logic [5:0]  opCode_i;
    logic [9:0]  xOpCode_i;
    logic        AA_i, LK_i, is64Bit_i;
    logic [23:0] imm_i;
    logic [63:0] instructionAddress_i, countReg_i, linkReg_i, targetAddrReg_i;
    logic [31:0] condReg_i;
    logic        valid_o, taken_o, illegal_o, linkWrite_o, ctrWrite_o;
    logic [63:0] target_o, linkVal_o, ctrVal_o;

    always #5 clock_i = ~clock_i;

    branch_resolve_unit dut (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .functionalUnitCode_i(functionalUnitCode_i),
        .instructionFormat_i(instructionFormat_i),
        .opCode_i(opCode_i), .xOpCode_i(xOpCode_i),
        .BO_i(BO_i), .BI_i(BI_i), .AA_i(AA_i), .LK_i(LK_i),
        .imm_i(imm_i), .instructionAddress_i(instructionAddress_i),
        .is64Bit_i(is64Bit_i), .condReg_i(condReg_i),
        .countReg_i(countReg_i), .linkReg_i(linkReg_i),
        .targetAddrReg_i(targetAddrReg_i),
        .valid_o(valid_o), .ready_i(ready_i), .taken_o(taken_o),
        .target_o(target_o), .illegal_o(illegal_o),
        .linkWrite_o(linkWrite_o), .linkVal_o(linkVal_o),
        .ctrWrite_o(ctrWrite_o), .ctrVal_o(ctrVal_o)
    );

    typedef struct {
        logic        taken, illegal, lw, cw;
        logic [63:0] tgt, lv, cv;
        int          age;
    } exp_t;

    exp_t q[$];
    exp_t rt[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of the branch on the input pins, with LR/CTR
    // taken from the youngest in-flight writer that has not retired.
    function automatic exp_t model(input bit skip_oldest);
        exp_t        e;
        logic [63:0] ctrSrc, lrSrc, cia4, tgt, ctrNew, m;
        longint      d;
        bit          iform, bform, lr, ctr, tar, cond, ctrOk, condOk, fc, fl;
        int          lo, sh;
        lo = skip_oldest ? 1 : 0;
        ctrSrc = countReg_i;
        lrSrc = linkReg_i;
        fc = 0;
        fl = 0;
        for (int i = q.size() - 1; i >= lo; i--) begin
            if (!fc && q[i].cw) begin ctrSrc = q[i].cv; fc = 1; end
            if (!fl && q[i].lw) begin lrSrc = q[i].lv; fl = 1; end
        end
        iform = instructionFormat_i == 5'd7 && opCode_i == 6'd18;
        bform = instructionFormat_i == 5'd2 && opCode_i == 6'd16;
        lr  = instructionFormat_i == 5'd18 && opCode_i == 6'd19 && xOpCode_i == 10'd16;
        ctr = instructionFormat_i == 5'd18 && opCode_i == 6'd19 && xOpCode_i == 10'd528
              && BO_i[2];
        tar = instructionFormat_i == 5'd18 && opCode_i == 6'd19 && xOpCode_i == 10'd560;
        e.illegal = !(iform || bform || lr || ctr || tar);
        cond = bform || lr || ctr || tar;
        e.cw = cond && !BO_i[2];
        ctrNew = ctrSrc - 64'd1;
        e.cv = ctrNew;
        cia4 = instructionAddress_i + 64'd4;
        tgt = cia4;
        if (iform) begin
            d = longint'(imm_i);
            if (imm_i[23]) d = d - 64'sd16777216;
            tgt = (AA_i ? 64'd0 : instructionAddress_i) + 64'(d * 4);
        end else if (bform) begin
            d = longint'(imm_i[13:0]);
            if (imm_i[13]) d = d - 64'sd16384;
            tgt = (AA_i ? 64'd0 : instructionAddress_i) + 64'(d * 4);
        end else if (lr) tgt = lrSrc - (lrSrc % 4);
        else if (ctr) tgt = ctrSrc - (ctrSrc % 4);
        else if (tar) tgt = targetAddrReg_i - (targetAddrReg_i % 4);
        if (BO_i[2]) ctrOk = 1;
        else begin
            m = is64Bit_i ? ctrNew : (ctrNew % 64'h1_0000_0000);
            ctrOk = (m != 0) != BO_i[1];
        end
        sh = 31 - int'(BI_i);
        condOk = BO_i[4] || (condReg_i[sh] == BO_i[3]);
        e.taken = !e.illegal && (iform || (ctrOk && condOk));
        e.tgt = e.taken ? tgt : cia4;
        e.lv = cia4;
        if (!is64Bit_i) begin
            e.tgt = e.tgt % 64'h1_0000_0000;
            e.lv = e.lv % 64'h1_0000_0000;
        end
        e.lw = LK_i && !e.illegal;
        e.age = 0;
        return e;
    endfunction

    task automatic cycle();
        bit   rdy, vexp, hs, acc;
        exp_t e, o;
        #1;
        rdy  = !flush_i && (q.size() < 2 || ready_i);
        vexp = q.size() > 0 && q[0].age >= 1;
        chk("ready_o", 64'(ready_o), 64'(rdy));
        chk("valid_o", 64'(valid_o), 64'(vexp));
        if (vexp) begin
            chk("taken_o", 64'(taken_o), 64'(q[0].taken));
            chk("illegal_o", 64'(illegal_o), 64'(q[0].illegal));
            chk("target_o", target_o, q[0].tgt);
            chk("linkWrite_o", 64'(linkWrite_o), 64'(q[0].lw));
            chk("linkVal_o", linkVal_o, q[0].lv);
            chk("ctrWrite_o", 64'(ctrWrite_o), 64'(q[0].cw));
            if (q[0].cw) chk("ctrVal_o", ctrVal_o, q[0].cv);
        end
        hs  = vexp && ready_i && !flush_i;
        acc = valid_i && rdy && functionalUnitCode_i == 3'd3;
        if (acc) e = model(hs);
        if (hs) begin
            o.taken = taken_o; o.illegal = illegal_o; o.tgt = target_o;
            o.lw = linkWrite_o; o.lv = linkVal_o;
            o.cw = ctrWrite_o; o.cv = ctrVal_o; o.age = 0;
            rt.push_back(o);
        end
        @(posedge clock_i);
        if (flush_i) q.delete();
        else begin
            foreach (q[i]) q[i].age++;
            if (hs) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clock_i);
    endtask

    task automatic idle();
        valid_i = 0; functionalUnitCode_i = 3'd0; flush_i = 0; ready_i = 1;
    endtask

    task automatic br(input logic [4:0] fmt, input logic [5:0] op,
                      input logic [9:0] xop, input logic [4:0] bo,
                      input logic [4:0] bi, input logic aa, input logic lk,
                      input logic [23:0] imm, input logic [63:0] cia);
        valid_i = 1; functionalUnitCode_i = 3'd3;
        instructionFormat_i = fmt; opCode_i = op; xOpCode_i = xop;
        BO_i = bo; BI_i = bi; AA_i = aa; LK_i = lk; imm_i = imm;
        instructionAddress_i = cia;
    endtask

    task automatic drain(input int n);
        exp_t z;
        int   k = 0;
        idle();
        while (rt.size() < n && k < 20) begin cycle(); k++; end
        chk("drain_count", 64'(rt.size()), 64'(n));
        z = '{default: 0};
        while (rt.size() < n) rt.push_back(z);
    endtask

    initial begin
        reset_i = 1; flush_i = 0; ready_i = 1; is64Bit_i = 1;
        condReg_i = 0; countReg_i = 0; linkReg_i = 0; targetAddrReg_i = 0;
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b1, 24'h10, 64'h1000);
        repeat (3) @(negedge clock_i);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_taken", 64'(taken_o), 64'd0);
        chk("rst_target", target_o, 64'd0);
        chk("rst_illegal", 64'(illegal_o), 64'd0);
        chk("rst_lw", 64'(linkWrite_o), 64'd0);
        chk("rst_lv", linkVal_o, 64'd0);
        chk("rst_cw", 64'(ctrWrite_o), 64'd0);
        chk("rst_cv", ctrVal_o, 64'd0);
        @(negedge clock_i);
        reset_i = 0; idle();
        repeat (2) cycle();

        rt.delete();
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b0, 24'h10, 64'h1000);
        cycle();
        idle();
        chk("lat_edge1", 64'(valid_o), 64'd0);
        cycle();
        chk("lat_edge2", 64'(valid_o), 64'd1);
        drain(1);
        chk("b_taken", 64'(rt[0].taken), 64'd1);
        chk("b_target", rt[0].tgt, 64'h1040);
        chk("b_nowrite", 64'({rt[0].lw, rt[0].cw}), 64'd0);

        rt.delete(); linkReg_i = 0;
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b1, 24'hFFFFFF, 64'h2000);
        cycle();
        br(5'd18, 6'd19, 10'd16, 5'b10100, 5'd0, 1'b0, 1'b0, 24'd0, 64'h3000);
        cycle();
        drain(2);
        chk("bl_target", rt[0].tgt, 64'h1FFC);
        chk("bl_linkval", rt[0].lv, 64'h2004);
        chk("bl_linkwr", 64'(rt[0].lw), 64'd1);
        chk("bclr_target", rt[1].tgt, 64'h2004);
        chk("bclr_taken", 64'(rt[1].taken), 64'd1);

        rt.delete(); countReg_i = 64'd2;
        repeat (3) begin
            br(5'd2, 6'd16, 10'd0, 5'b10000, 5'd0, 1'b0, 1'b0, 24'd8, 64'h4000);
            cycle();
        end
        drain(3);
        chk("bdnz0_ctr", rt[0].cv, 64'd1);
        chk("bdnz1_ctr", rt[1].cv, 64'd0);
        chk("bdnz2_ctr", rt[2].cv, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bdnz_taken", 64'({rt[0].taken, rt[1].taken, rt[2].taken}), 64'b101);
        chk("bdnz_ctrwr", 64'({rt[0].cw, rt[1].cw, rt[2].cw}), 64'b111);

        rt.delete(); condReg_i = 32'h2000_0000;
        br(5'd2, 6'd16, 10'd0, 5'b01100, 5'd2, 1'b0, 1'b0, 24'd5, 64'h5000);
        cycle();
        condReg_i = 32'h0;
        cycle();
        drain(2);
        chk("bc_t_taken", 64'(rt[0].taken), 64'd1);
        chk("bc_t_target", rt[0].tgt, 64'h5014);
        chk("bc_nt_taken", 64'(rt[1].taken), 64'd0);
        chk("bc_nt_target", rt[1].tgt, 64'h5004);

        rt.delete(); is64Bit_i = 0;
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b1, 24'hFFFFFE,
           64'hFFFF_FFFF_FFFF_FFF0);
        cycle();
        drain(1);
        is64Bit_i = 1;
        chk("m32_target", rt[0].tgt, 64'h0000_0000_FFFF_FFE8);
        chk("m32_linkval", rt[0].lv, 64'h0000_0000_FFFF_FFF4);

        rt.delete();
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b0, 24'd1, 64'h6000);
        ready_i = 0;
        cycle();
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b0, 24'd2, 64'h7000);
        ready_i = 0;
        cycle();
        idle(); ready_i = 0;
        repeat (3) begin
            cycle();
            chk("bp_ready", 64'(ready_o), 64'd0);
            chk("bp_hold", target_o, 64'h6004);
        end
        flush_i = 1;
        cycle();
        flush_i = 0; ready_i = 1;
        chk("flush_valid", 64'(valid_o), 64'd0);
        repeat (3) cycle();
        chk("flush_empty", 64'(rt.size()), 64'd0);

        rt.delete();
        br(5'd18, 6'd19, 10'd999, 5'b10100, 5'd0, 1'b0, 1'b1, 24'd0, 64'h8000);
        cycle();
        br(5'd18, 6'd19, 10'd528, 5'b10000, 5'd0, 1'b0, 1'b0, 24'd0, 64'h9000);
        cycle();
        drain(2);
        chk("xop999_illegal", 64'(rt[0].illegal), 64'd1);
        chk("xop999_taken", 64'(rt[0].taken), 64'd0);
        chk("xop999_target", rt[0].tgt, 64'h8004);
        chk("xop999_nolink", 64'(rt[0].lw), 64'd0);
        chk("bcctr_dec_illegal", 64'(rt[1].illegal), 64'd1);

        rt.delete();
        br(5'd7, 6'd18, 10'd0, 5'd0, 5'd0, 1'b0, 1'b1, 24'd1, 64'hA000);
        functionalUnitCode_i = 3'd1;
        cycle();
        idle();
        repeat (3) cycle();
        chk("foreign_dropped", 64'(rt.size()), 64'd0);

        for (int k = 0; k < 3000; k++) begin
            valid_i = $urandom_range(0, 9) < 7;
            functionalUnitCode_i = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd3;
            case ($urandom_range(0, 3))
                0: begin instructionFormat_i = 5'd7; opCode_i = 6'd18; end
                1: begin instructionFormat_i = 5'd2; opCode_i = 6'd16; end
                2: begin instructionFormat_i = 5'd18; opCode_i = 6'd19; end
                default: begin
                    instructionFormat_i = 5'($urandom); opCode_i = 6'($urandom);
                end
            endcase
            case ($urandom_range(0, 3))
                0: xOpCode_i = 10'd16;
                1: xOpCode_i = 10'd528;
                2: xOpCode_i = 10'd560;
                default: xOpCode_i = 10'($urandom);
            endcase
            BO_i = 5'($urandom); BI_i = 5'($urandom);
            AA_i = 1'($urandom); LK_i = 1'($urandom);
            imm_i = 24'($urandom);
            instructionAddress_i = {32'($urandom), 30'($urandom), 2'b00};
            is64Bit_i = 1'($urandom);
            condReg_i = 32'($urandom);
            case ($urandom_range(0, 3))
                0, 1: countReg_i = 64'($urandom_range(0, 3));
                2: countReg_i = {32'($urandom_range(0, 1)), 32'($urandom_range(0, 2))};
                default: countReg_i = {32'($urandom), 32'($urandom)};
            endcase
            linkReg_i = {32'($urandom), 32'($urandom)};
            targetAddrReg_i = {32'($urandom), 32'($urandom)};
            ready_i = $urandom_range(0, 3) != 0;
            flush_i = $urandom_range(0, 39) == 0;
            cycle();
        end
        idle();
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
